// File: rtl/qcl_add_sub_pipe.sv
// Multi-lane unsigned add/sub with the carry chain split over latency_p register stages.
// Optional output saturation is enabled with `define QCL_ADD_SUB_PIPE_SAT_EN.
module qcl_add_sub_pipe #(
  parameter int width_p   = 32,
  parameter int lanes_p   = 1,
  parameter int latency_p = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       v_i,
  output logic                       ready_o,
  input  logic [lanes_p*width_p-1:0] a_i,
  input  logic [lanes_p*width_p-1:0] b_i,
  input  logic [lanes_p-1:0]         sub_i,
  input  logic [lanes_p-1:0]         c_i,
  output logic                       v_o,
  input  logic                       ready_i,
  output logic [lanes_p*width_p-1:0] s_o,
  output logic [lanes_p-1:0]         c_o
);

  localparam int stages_lp = (latency_p > 0) ? latency_p : 1;
  localparam int seg_w_lp  = (width_p + stages_lp - 1) / stages_lp;

  typedef logic [width_p-1:0] word_t;

  // Adds segment k of a and b plus cin; returns {carry_out, segment sum placed at its bit offset}.
  // Segments past the top of the word are empty and simply pass the carry through.
  function automatic logic [width_p:0] seg_add(input word_t a, input word_t b,
                                               input logic cin, input int k);
    logic [width_p:0] one, m, am, bm, cv, t;
    logic             cy;
    int               lo, len;
    lo = k * seg_w_lp;
    if (lo > width_p) lo = width_p;
    len = width_p - lo;
    if (len > seg_w_lp) len = seg_w_lp;
    one    = '0;
    one[0] = 1'b1;
    cv     = '0;
    cv[0]  = cin;
    m  = (one << len) - one;
    am = ({1'b0, a} >> lo) & m;
    bm = ({1'b0, b} >> lo) & m;
    t  = am + bm + cv;
    cy = (((t >> len) & one) != '0);
    return {cy, word_t'((t & m) << lo)};
  endfunction

`ifdef QCL_ADD_SUB_PIPE_SAT_EN
  // Add overflow pins to all-ones, subtract underflow pins to zero.
  function automatic word_t clamp(input word_t s, input logic cy, input logic sub);
    if (!sub && cy) return '1;
    if (sub && !cy) return '0;
    return s;
  endfunction
`endif

  generate
    if (latency_p == 0) begin : g_comb
      logic             unused_ctl;
      logic [width_p:0] r0;

      assign unused_ctl = clk_i ^ reset_n_i;
      assign v_o        = v_i;
      assign ready_o    = ready_i;

      always_comb begin
        s_o = '0;
        c_o = '0;
        r0  = '0;
        for (int l = 0; l < lanes_p; l++) begin
          r0 = seg_add(a_i[l*width_p +: width_p],
                       sub_i[l] ? ~b_i[l*width_p +: width_p] : b_i[l*width_p +: width_p],
                       c_i[l] ^ sub_i[l], 0);
`ifdef QCL_ADD_SUB_PIPE_SAT_EN
          s_o[l*width_p +: width_p] = clamp(r0[width_p-1:0], r0[width_p], sub_i[l]);
`else
          s_o[l*width_p +: width_p] = r0[width_p-1:0];
`endif
          c_o[l] = r0[width_p] ^ sub_i[l];
        end
      end
    end else begin : g_pipe
      logic [latency_p-1:0] vld_all;
      logic [latency_p-1:0] load;

      // A stage may load unless it and every stage after it is full and the output is stalled.
      always_comb begin : p_load
        logic full;
        full = 1'b1;
        load = '0;
        for (int k = latency_p - 1; k >= 0; k--) begin
          full    = full & vld_all[k];
          load[k] = ready_i | !full;
        end
      end

      for (genvar k = 0; k < latency_p; k++) begin : g_stage
        word_t            a_in   [lanes_p];
        word_t            b_in   [lanes_p];
        word_t            s_in   [lanes_p];
        logic             cy_in  [lanes_p];
        logic             sub_in [lanes_p];
        logic             vld_in;
        word_t            s_n    [lanes_p];
        logic             cy_n   [lanes_p];
        logic [width_p:0] r;
        word_t            s_p    [lanes_p];
        logic             cy_p   [lanes_p];
        logic             sub_p  [lanes_p];
        logic             vld_p;

        if (k == 0) begin : g_first
          // Subtract is folded into an add of ~B with inverted borrow on entry.
          always_comb begin
            vld_in = v_i;
            for (int l = 0; l < lanes_p; l++) begin
              a_in[l]   = a_i[l*width_p +: width_p];
              b_in[l]   = sub_i[l] ? ~b_i[l*width_p +: width_p] : b_i[l*width_p +: width_p];
              cy_in[l]  = c_i[l] ^ sub_i[l];
              sub_in[l] = sub_i[l];
              s_in[l]   = '0;
            end
          end
        end else begin : g_next
          always_comb begin
            vld_in = g_stage[k-1].vld_p;
            for (int l = 0; l < lanes_p; l++) begin
              a_in[l]   = g_stage[k-1].g_fwd.a_p[l];
              b_in[l]   = g_stage[k-1].g_fwd.b_p[l];
              cy_in[l]  = g_stage[k-1].cy_p[l];
              sub_in[l] = g_stage[k-1].sub_p[l];
              s_in[l]   = g_stage[k-1].s_p[l];
            end
          end
        end

        always_comb begin
          r = '0;
          for (int l = 0; l < lanes_p; l++) begin
            r       = seg_add(a_in[l], b_in[l], cy_in[l], k);
            s_n[l]  = s_in[l] | r[width_p-1:0];
            cy_n[l] = r[width_p];
`ifdef QCL_ADD_SUB_PIPE_SAT_EN
            if (k == latency_p - 1) s_n[l] = clamp(s_n[l], cy_n[l], sub_in[l]);
`endif
          end
        end

        // ---- stage k register boundary ----
        always_ff @(posedge clk_i or negedge reset_n_i) begin
          if (!reset_n_i) vld_p <= 1'b0;
          else if (load[k]) vld_p <= vld_in;
        end

        always_ff @(posedge clk_i) begin
          if (load[k]) begin
            for (int l = 0; l < lanes_p; l++) begin
              s_p[l]   <= s_n[l];
              cy_p[l]  <= cy_n[l];
              sub_p[l] <= sub_in[l];
            end
          end
        end

        // Operand words only travel as far as the last segment that still needs them.
        if (k < latency_p - 1) begin : g_fwd
          word_t a_p [lanes_p];
          word_t b_p [lanes_p];
          always_ff @(posedge clk_i) begin
            if (load[k]) begin
              for (int l = 0; l < lanes_p; l++) begin
                a_p[l] <= a_in[l];
                b_p[l] <= b_in[l];
              end
            end
          end
        end

        assign vld_all[k] = vld_p;
      end

      assign v_o     = vld_all[latency_p-1];
      assign ready_o = load[0];

      // Data registers are not reset, so results are forced to zero whenever v_o is low.
      always_comb begin
        s_o = '0;
        c_o = '0;
        for (int l = 0; l < lanes_p; l++) begin
          if (v_o) begin
            s_o[l*width_p +: width_p] = g_stage[latency_p-1].s_p[l];
            c_o[l] = g_stage[latency_p-1].cy_p[l] ^ g_stage[latency_p-1].sub_p[l];
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_qcl_add_sub_pipe.sv
// Bench for qcl_add_sub_pipe: 8x2 lanes at latency 2 against a queue-based model,
// plus a latency-0 instance and a 1-bit latency-1 instance.
module tb_qcl_add_sub_pipe;
  localparam int W = 8;
  localparam int N = 2;
  localparam int L = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic            v, ready, v_out, ready_in;
  logic [N*W-1:0]  a, b, s;
  logic [N-1:0]    sub, c, co;

  logic            z_v, z_ready, z_v_out, z_ready_in;
  logic [N*W-1:0]  z_a, z_b, z_s;
  logic [N-1:0]    z_sub, z_c, z_co;

  logic o_v, o_ready, o_v_out, o_ready_in;
  logic o_a, o_b, o_s, o_sub, o_c, o_co;

  qcl_add_sub_pipe #(.width_p(W), .lanes_p(N), .latency_p(L)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v), .ready_o(ready), .a_i(a), .b_i(b),
    .sub_i(sub), .c_i(c), .v_o(v_out), .ready_i(ready_in), .s_o(s), .c_o(co));

  qcl_add_sub_pipe #(.width_p(W), .lanes_p(N), .latency_p(0)) dut_z (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(z_v), .ready_o(z_ready), .a_i(z_a), .b_i(z_b),
    .sub_i(z_sub), .c_i(z_c), .v_o(z_v_out), .ready_i(z_ready_in), .s_o(z_s), .c_o(z_co));

  qcl_add_sub_pipe #(.width_p(1), .lanes_p(1), .latency_p(1)) dut_o (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(o_v), .ready_o(o_ready), .a_i(o_a), .b_i(o_b),
    .sub_i(o_sub), .c_i(o_c), .v_o(o_v_out), .ready_i(o_ready_in), .s_o(o_s), .c_o(o_co));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Plain-arithmetic reference: returns {carry_or_borrow, result} for a w-bit lane.
  function automatic logic [64:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input logic sb, input logic cin, input int w);
    logic [65:0] tx, ty, tc, tot;
    logic [63:0] mask, r;
    logic        cy;
    mask = (64'd1 << w) - 64'd1;
    tx = {2'b00, x};
    ty = {2'b00, y};
    tc = '0;
    tc[0] = cin;
    if (!sb) begin
      tot = tx + ty + tc;
      cy  = tot > {2'b00, mask};
    end else begin
      cy  = tx < (ty + tc);
      tot = tx - ty - tc;
    end
    r = tot[63:0] & mask;
`ifdef QCL_ADD_SUB_PIPE_SAT_EN
    if (cy) r = sb ? 64'd0 : mask;
`endif
    return {cy, r};
  endfunction

  function automatic logic [63:0] exp_beat(input logic [15:0] xa, input logic [15:0] xb,
                                           input logic [1:0] xs, input logic [1:0] xc);
    logic [64:0] r0, r1;
    logic [63:0] e;
    r0 = model({56'd0, xa[7:0]}, {56'd0, xb[7:0]}, xs[0], xc[0], W);
    r1 = model({56'd0, xa[15:8]}, {56'd0, xb[15:8]}, xs[1], xc[1], W);
    e = '0;
    e[17:0] = {r1[64], r0[64], r1[7:0], r0[7:0]};
    return e;
  endfunction

  typedef struct {
    logic [63:0] res;
    int          acc;
  } beat_t;

  beat_t       q[$];
  int          cyc = 0;
  bit          mon_en = 0;
  int          run = 0, max_run = 0, waits = 0;
  logic        exp_v;
  logic [63:0] got;

  // Occupancy model: a beat shows at the output exactly L cycles after acceptance and
  // stays there until taken; stage 0 refuses only when L beats are held and output is stalled.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      exp_v = 1'b0;
      if (q.size() > 0) exp_v = (cyc - q[0].acc) >= L;
      check("v_o", 64'(v_out), 64'(exp_v));
      check("ready_o", 64'(ready), 64'(ready_in | (q.size() < L)));
      if (v_out && q.size() > 0) begin
        got = '0;
        got[17:0] = {co, s};
        check("beat", got, q[0].res);
        if (ready_in) q.delete(0);
      end
      if (v && ready) q.push_back('{exp_beat(a, b, sub, c), cyc});
      run = v_out ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
    cyc++;
  end

  task automatic send(input logic [15:0] xa, input logic [15:0] xb,
                      input logic [1:0] xs, input logic [1:0] xc);
    int n;
    n = 0;
    v = 1'b1; a = xa; b = xb; sub = xs; c = xc;
    @(negedge clk);
    while (!ready) begin
      waits++;
      n++;
      if (n > 200) begin
        check("send_timeout", 64'(n), 64'd0);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    v = 1'b0;
  endtask

  task automatic send_rand();
    send(16'($urandom), 16'($urandom), 2'($urandom), 2'($urandom));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [64:0] m0, m1;
    rst_n = 1'b0; v = 1'b0; ready_in = 1'b1; a = '0; b = '0; sub = '0; c = '0;
    z_v = 1'b0; z_ready_in = 1'b0; z_a = '0; z_b = '0; z_sub = '0; z_c = '0;
    o_v = 1'b0; o_ready_in = 1'b1; o_a = 1'b0; o_b = 1'b0; o_sub = 1'b0; o_c = 1'b0;

    #2;
    check("rst_v_o", 64'(v_out), 64'd0);
    check("rst_s_o", 64'(s), 64'd0);
    check("rst_c_o", 64'(co), 64'd0);
    check("rst_o_v_o", 64'(o_v_out), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rst_ready_o", 64'(ready), 64'd1);
    check("rst_o_ready_o", 64'(o_ready), 64'd1);
    mon_en = 1'b1;

    // Wrap add on lane 0, plain add on lane 1.
    send({8'h03, 8'hFF}, {8'h04, 8'h01}, 2'b00, 2'b00);
    check("t1_not_early", 64'(v_out), 64'd0);
    @(posedge clk); #1;
    check("t1_v_o", 64'(v_out), 64'd1);
`ifdef QCL_ADD_SUB_PIPE_SAT_EN
    check("t1_s0", 64'(s[7:0]), 64'h00FF);
`else
    check("t1_s0", 64'(s[7:0]), 64'h0000);
`endif
    check("t1_c0", 64'(co[0]), 64'd1);
    check("t1_s1", 64'(s[15:8]), 64'h07);
    check("t1_c1", 64'(co[1]), 64'd0);

    // Borrowing subtract on lane 1, non-borrowing subtract on lane 0.
    @(posedge clk); #1;
    send({8'h10, 8'h20}, {8'h20, 8'h10}, 2'b11, 2'b10);
    @(posedge clk); #1;
`ifdef QCL_ADD_SUB_PIPE_SAT_EN
    check("t2_s1", 64'(s[15:8]), 64'h00);
`else
    check("t2_s1", 64'(s[15:8]), 64'hEF);
`endif
    check("t2_c1", 64'(co[1]), 64'd1);
    check("t2_s0", 64'(s[7:0]), 64'h10);
    check("t2_c0", 64'(co[0]), 64'd0);

    // Streaming at full rate.
    repeat (3) @(posedge clk);
    #1;
    waits = 0; run = 0; max_run = 0;
    for (int i = 0; i < 16; i++) send_rand();
    repeat (4) @(posedge clk);
    #1;
    check("stream_no_stall", 64'(waits), 64'd0);
    check("stream_run", 64'(max_run), 64'd16);
    check("stream_drained", 64'(q.size()), 64'd0);

    // Five-cycle back-pressure window mid-stream.
    waits = 0;
    fork
      begin
        for (int i = 0; i < 12; i++) send_rand();
      end
      begin
        repeat (4) @(posedge clk);
        #1 ready_in = 1'b0;
        repeat (5) @(posedge clk);
        #1 ready_in = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    check("bp_ready_dropped", 64'(waits > 0), 64'd1);
    check("bp_drained", 64'(q.size()), 64'd0);

    // Random gaps with random back-pressure.
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send_rand();
        end
      end
      begin
        for (int i = 0; i < 70; i++) begin
          @(posedge clk);
          #1 ready_in = ($urandom_range(0, 2) != 0);
        end
        ready_in = 1'b1;
      end
    join
    ready_in = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("rand_drained", 64'(q.size()), 64'd0);

    // Reset between edges with two beats in flight.
    ready_in = 1'b0;
    send_rand();
    send_rand();
    check("rst_mid_inflight", 64'(q.size()), 64'd2);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_v_o", 64'(v_out), 64'd0);
    check("rst_mid_s_o", 64'(s), 64'd0);
    check("rst_mid_c_o", 64'(co), 64'd0);
    q.delete();
    #1 rst_n = 1'b1;
    ready_in = 1'b1;
    #1;
    check("rst_mid_ready_o", 64'(ready), 64'd1);
    repeat (5) @(posedge clk);
    #1;

    // Latency 0: purely combinational.
    for (int i = 0; i < 24; i++) begin
      if (i == 0) begin
        z_a = {8'h10, 8'hFF}; z_b = {8'h20, 8'h01}; z_sub = 2'b10; z_c = 2'b10;
      end else begin
        z_a = 16'($urandom); z_b = 16'($urandom); z_sub = 2'($urandom); z_c = 2'($urandom);
      end
      z_v = 1'($urandom); z_ready_in = 1'($urandom);
      #1;
      m0 = model({56'd0, z_a[7:0]}, {56'd0, z_b[7:0]}, z_sub[0], z_c[0], W);
      m1 = model({56'd0, z_a[15:8]}, {56'd0, z_b[15:8]}, z_sub[1], z_c[1], W);
      check("l0_s", 64'(z_s), 64'({m1[7:0], m0[7:0]}));
      check("l0_c", 64'(z_co), 64'({m1[64], m0[64]}));
      check("l0_v_o", 64'(z_v_out), 64'(z_v));
      check("l0_ready_o", 64'(z_ready), 64'(z_ready_in));
    end

    // Width 1, latency 1: 1+1+1 and 0-1-0.
    @(posedge clk); #1;
    o_a = 1'b1; o_b = 1'b1; o_c = 1'b1; o_sub = 1'b0; o_v = 1'b1;
    @(negedge clk);
    check("w1_ready_o", 64'(o_ready), 64'd1);
    check("w1_not_early", 64'(o_v_out), 64'd0);
    @(posedge clk); #1;
    o_v = 1'b0;
    check("w1_add_v_o", 64'(o_v_out), 64'd1);
    check("w1_add_s", 64'(o_s), 64'd1);
    check("w1_add_c", 64'(o_co), 64'd1);
    o_a = 1'b0; o_b = 1'b1; o_c = 1'b0; o_sub = 1'b1; o_v = 1'b1;
    @(posedge clk); #1;
    o_v = 1'b0;
    check("w1_sub_v_o", 64'(o_v_out), 64'd1);
`ifdef QCL_ADD_SUB_PIPE_SAT_EN
    check("w1_sub_s", 64'(o_s), 64'd0);
`else
    check("w1_sub_s", 64'(o_s), 64'd1);
`endif
    check("w1_sub_c", 64'(o_co), 64'd1);
    @(posedge clk); #1;
    check("w1_idle_v_o", 64'(o_v_out), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
